// File: rtl/dm_result_dumper.sv
// Snoops the CPU done-flag write, halts the CPU and streams NUM_WORDS answer words out of DM.
// 3 cycles per word (read, capture, send); the word is held on out_data until out_ready accepts it.
module dm_result_dumper #(
    parameter int unsigned ADDR_W       = 16,
    parameter logic [31:0] ANSWER_START = 32'h0000_9000,
    parameter logic [31:0] DONE_ADDR    = 32'h0000_FFFC,
    parameter logic [7:0]  DONE_VALUE   = 8'hFF,
    parameter int unsigned NUM_WORDS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cpu_dm_we,
    input  logic [ADDR_W-1:0] cpu_dm_addr,
    input  logic [31:0]       cpu_dm_wdata,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [6:0]        out_index,
    output logic              out_last,
    output logic              cpu_halt,
    output logic              busy,
    output logic              dump_done
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_FINISH} state_t;

    localparam logic [6:0]        LAST_IDX  = 7'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] DONE_TRNC = DONE_ADDR[ADDR_W-1:0];

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_idx;
    logic [31:0] r_out_data;
    logic [6:0]  r_out_index;
    logic        r_out_last;
    logic        w_hit;
    logic        w_unused;

    // Only byte 0 of the done word carries the flag; the other lanes are don't-care.
    assign w_hit    = cpu_dm_we[0] && (cpu_dm_addr == DONE_TRNC) && (cpu_dm_wdata[7:0] == DONE_VALUE);
    assign w_unused = ^{cpu_dm_we[3:1], cpu_dm_wdata[31:8]};

    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        rd_req    = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        cpu_halt  = 1'b0;
        busy      = 1'b0;
        dump_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) w_next = S_READ;
            end
            S_READ: begin
                rd_req   = 1'b1;
                rd_addr  = ADDR_W'(ANSWER_START + {23'd0, r_idx, 2'b00});
                cpu_halt = 1'b1;
                busy     = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                cpu_halt = 1'b1;
                busy     = 1'b1;
                w_next   = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                cpu_halt  = 1'b1;
                busy      = 1'b1;
                if (out_ready) w_next = r_out_last ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                dump_done = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) r_idx <= '0;
                end
                S_WAIT: begin
                    r_out_data  <= rd_data;
                    r_out_index <= r_idx;
                    r_out_last  <= (r_idx == LAST_IDX);
                end
                S_SEND: begin
                    if (out_ready && !r_out_last) r_idx <= r_idx + 7'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_result_dumper.sv
// Bench for dm_result_dumper: DM model behind the read port, expected beats derived from the memory image.
module tb_dm_result_dumper;
    localparam int NW = 32;
    localparam logic [31:0] ANS = 32'h0000_9000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  cpu_dm_we;
    logic [15:0] cpu_dm_addr;
    logic [31:0] cpu_dm_wdata;
    logic        rd_req, out_valid, out_ready, out_last, cpu_halt, busy, dump_done;
    logic [15:0] rd_addr;
    logic [31:0] rd_data, out_data;
    logic [6:0]  out_index;

    logic        b_rd_req, b_out_valid, b_out_ready, b_out_last, b_cpu_halt, b_busy, b_dump_done;
    logic [15:0] b_rd_addr;
    logic [31:0] b_rd_data, b_out_data;
    logic [6:0]  b_out_index;

    logic [31:0] mem [0:16383];
    logic [15:0] wrap_seq [4];

    int n_total, n_bad;
    int beats, first_v_k, done_k, acc3_k, acc4_k, v3_cycles;

    dm_result_dumper u_dut (
        .clk(clk), .rst(rst), .cpu_dm_we(cpu_dm_we), .cpu_dm_addr(cpu_dm_addr),
        .cpu_dm_wdata(cpu_dm_wdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .cpu_halt(cpu_halt), .busy(busy), .dump_done(dump_done)
    );

    dm_result_dumper #(.ANSWER_START(32'h0000_FFF8), .NUM_WORDS(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .cpu_dm_we(cpu_dm_we), .cpu_dm_addr(cpu_dm_addr),
        .cpu_dm_wdata(cpu_dm_wdata), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_index(b_out_index), .out_last(b_out_last), .cpu_halt(b_cpu_halt), .busy(b_busy),
        .dump_done(b_dump_done)
    );

    // Synchronous-read SRAM second port shared by both instances.
    always @(posedge clk) begin
        if (rd_req)   rd_data   <= mem[rd_addr[15:2]];
        if (b_rd_req) b_rd_data <= mem[b_rd_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input int i);
        logic [31:0] a;
        a = ANS + 32'(i) * 32'd4;
        return a[15:0];
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        logic [15:0] a;
        a = exp_addr(i);
        return mem[a[15:2]];
    endfunction

    task automatic check_zero(input string p);
        chk({p, "_rd_req"},    32'(rd_req),    0);
        chk({p, "_rd_addr"},   32'(rd_addr),   0);
        chk({p, "_out_valid"}, 32'(out_valid), 0);
        chk({p, "_out_data"},  out_data,       0);
        chk({p, "_out_index"}, 32'(out_index), 0);
        chk({p, "_out_last"},  32'(out_last),  0);
        chk({p, "_cpu_halt"},  32'(cpu_halt),  0);
        chk({p, "_busy"},      32'(busy),      0);
        chk({p, "_dump_done"}, 32'(dump_done), 0);
    endtask

    task automatic cpu_wr(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        cpu_dm_we = we; cpu_dm_addr = a; cpu_dm_wdata = d;
        @(posedge clk); #1;
        cpu_dm_we = 4'd0; cpu_dm_addr = 16'd0; cpu_dm_wdata = 32'd0;
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    // Called right after the edge that accepted the DONE write (cycle T+1 = k 1).
    // mode 0: ready=1, DONE rewritten during word 5, constant image; 1: random ready with a 5-cycle
    // stall on word 3; 2: ready=1, reset pulsed in the SEND cycle of word 10; 3: ready=1.
    task automatic run_dump(input int mode);
        int k, wc, stall;
        logic [31:0] ew;
        beats = 0; first_v_k = -1; done_k = -1; acc3_k = -1; acc4_k = -1; v3_cycles = 0;
        k = 1; wc = 0; stall = 0;
        for (int g = 0; g < 3000; g++) begin
            if (mode == 1) begin
                if (beats == 3)      out_ready = (stall >= 5);
                else if (beats == 4) out_ready = 1'b1;
                else                 out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (mode == 0 && beats == 5) begin
                cpu_dm_we = 4'b0001; cpu_dm_addr = 16'hFFFC; cpu_dm_wdata = 32'h0000_00FF;
            end else begin
                cpu_dm_we = 4'd0; cpu_dm_addr = 16'd0; cpu_dm_wdata = 32'd0;
            end
            if (mode == 2 && beats == 10 && wc == 2) rst = 1'b0;
            @(negedge clk);
            if (out_valid && first_v_k < 0) first_v_k = k;
            if (rd_req) chk("rd_addr", 32'(rd_addr), 32'(exp_addr(beats)));
            if (!dump_done) chk("halt_during_dump", 32'(cpu_halt), 1);
            if (out_valid) begin
                ew = (mode == 0) ? 32'h1000_0000 + 32'(beats) : exp_word(beats);
                chk("out_data", out_data, ew);
                chk("out_index", 32'(out_index), beats);
                chk("out_last", 32'(out_last), 32'(beats == NW - 1));
                if (beats == 3) begin
                    v3_cycles++;
                    if (!out_ready) stall++;
                end
            end
            if (dump_done) begin
                done_k = k;
                break;
            end
            if (out_valid && out_ready && rst) begin
                if (beats == 3) acc3_k = k;
                if (beats == 4) acc4_k = k;
                beats++;
                wc = 0;
            end else begin
                wc++;
            end
            if (!rst) begin
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                check_zero("abort");
                return;
            end
            @(posedge clk); #1;
            k++;
        end
        cpu_dm_we = 4'd0; cpu_dm_addr = 16'd0; cpu_dm_wdata = 32'd0;
    endtask

    initial begin
        int bn, bv;
        n_total = 0; n_bad = 0;
        rst = 1'b0; out_ready = 1'b0; b_out_ready = 1'b1;
        cpu_dm_we = 4'd0; cpu_dm_addr = 16'd0; cpu_dm_wdata = 32'd0;
        wrap_seq = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1; rst = 1'b1;

        // Non-matching writes must leave the block idle.
        cpu_wr(4'b1111, 16'hFFFC, 32'h0000_00FE);
        cpu_wr(4'b1110, 16'hFFFC, 32'h0000_00FF);
        cpu_wr(4'b0001, 16'hFFF8, 32'h0000_00FF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignore_rd_req", 32'(rd_req), 0);
            chk("ignore_busy", 32'(busy), 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < NW; i++) mem[32'h2400 + i] = 32'h1000_0000 + 32'(i);
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        run_dump(0);
        chk("t1_first_valid_cycle", first_v_k, 3);
        chk("t1_done_cycle", done_k, 3 * NW + 1);
        chk("t1_beats", beats, NW);
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("finish_dump_done", 32'(dump_done), 1);
        chk("finish_halt", 32'(cpu_halt), 0);
        chk("finish_busy", 32'(busy), 0);
        chk("finish_rd_req", 32'(rd_req), 0);
        chk("finish_valid", 32'(out_valid), 0);

        for (int i = 0; i < NW; i++) mem[32'h2400 + i] = $urandom;
        rst_pulse();
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        run_dump(1);
        chk("bp_beats", beats, NW);
        chk("bp_word3_valid_cycles", v3_cycles, 6);
        chk("bp_word4_gap", acc4_k - acc3_k, 3);
        chk("bp_done_seen", 32'(done_k > 0), 1);

        rst_pulse();
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        run_dump(2);
        chk("abort_beats", beats, 10);
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        run_dump(3);
        chk("restart_done_cycle", done_k, 3 * NW + 1);
        chk("restart_beats", beats, NW);

        // Wrapping instance: 4 words starting 8 bytes below the top of DM.
        rst_pulse();
        cpu_wr(4'b0001, 16'hFFFC, 32'h0000_00FF);
        bn = 0; bv = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (b_rd_req) begin
                if (bn < 4) chk("wrap_rd_addr", 32'(b_rd_addr), 32'(wrap_seq[bn]));
                else        chk("wrap_extra_read", bn, 3);
                bn++;
            end
            if (b_out_valid && bv < 4) begin
                chk("wrap_data", b_out_data, mem[wrap_seq[bv][15:2]]);
                chk("wrap_last", 32'(b_out_last), 32'(bv == 3));
                bv++;
            end
            if (b_dump_done) break;
            @(posedge clk); #1;
        end
        chk("wrap_reads", bn, 4);
        chk("wrap_done", 32'(b_dump_done), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
